// File: rtl/spi_slave_rx_pkg.sv
// Shared SPI definitions: frame width, counter width, idle levels and FSM states.
package spi_slave_rx_pkg;

  localparam int unsigned SPI_DATA_W      = 16;
  localparam int unsigned SPI_CNT_W       = 5;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  // Mode 0: s_clk idles low, data sampled on the rising edge.
  localparam logic SPI_SCLK_IDLE = 1'b0;
  localparam logic SPI_CS_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_CS = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Ports: clk/rst (sync, active-high), d (async input), q (synchronized output).
// RST_VAL is the idle level the chain is forced to during reset.
module spi_slave_rx_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 target endpoint: oversamples s_clk/spi_cs_l/mosi in the clk domain,
// shifts in one MSB-first word per frame, shifts a reply out on miso, and hands
// received words to the system through a valid/ready holding register.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   s_clk, spi_cs_l    SPI clock and active-low chip select (async)
//   mosi / miso        serial data in / out
//   tx_data            reply word, captured at frame start
//   rx_data, rx_valid  received word and its valid flag; rx_ready accepts it
//   frame_err          1-cycle pulse: frame too short or too long
//   overrun            1-cycle pulse: word dropped, holding register full
//   busy               high while shifting
//   bit_cnt            bits received in the current frame
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 spi_cs_l,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [DATA_W-1:0]    tx_data,
  output logic [DATA_W-1:0]    rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [SPI_CNT_W-1:0] bit_cnt
);

  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic sclk_s, cs_s, mosi_s;

  spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(s_clk), .q(sclk_s)
  );
  spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CS_IDLE)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs_l), .q(cs_s)
  );
  spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  spi_state_e           state_q, state_d;
  logic                 sclk_dly_q, sclk_dly_d;
  logic                 cs_dly_q, cs_dly_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DATA_W-1:0]    rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]    tx_sr_q, tx_sr_d;
  logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 extra_q, extra_d;
  logic                 miso_q, miso_d;
  logic [DATA_W-1:0]    rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;
  logic sync_ok_c, cs_high_c, commit_c;

  // Edge detect on synchronized inputs against a one-cycle delay flop.
  always_comb begin
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_s;
    sclk_rise_c =  sclk_s & ~sclk_dly_q;
    sclk_fall_c = ~sclk_s &  sclk_dly_q;
    cs_fall_c   = ~cs_s   &  cs_dly_q;
    cs_rise_c   =  cs_s   & ~cs_dly_q;
  end

  // After reset the synchronizers hold forced idle levels; only once they have
  // refilled with real samples may a high cs release WAIT_CS. This lets the block
  // leave WAIT_CS when cs was already idle at reset, yet ignore a frame in flight.
  always_comb begin
    sync_ok_c   = (flush_cnt_q == FLUSH_W'(SYNC_STAGES));
    flush_cnt_d = sync_ok_c ? flush_cnt_q : flush_cnt_q + FLUSH_W'(1);
    cs_high_c   = sync_ok_c & cs_s;
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    extra_d     = extra_q;
    miso_d      = (state_q == ST_SHIFT) ? miso_q : 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    commit_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall_c) begin
          state_d   = ST_SHIFT;
          tx_sr_d   = tx_data;
          miso_d    = tx_data[DATA_W-1];
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == SPI_CNT_W'(DATA_W)) begin
          // Full word: commit and wait for cs to release.
          commit_c = 1'b1;
          miso_d   = 1'b0;
          extra_d  = 1'b0;
          state_d  = cs_rise_c ? ST_IDLE : ST_WAIT_CS;
        end else if (cs_rise_c) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          if (sclk_rise_c) begin
            rx_sr_d   = {rx_sr_q[DATA_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
          end
          if (sclk_fall_c) begin
            tx_sr_d = tx_sr_q << 1;
            miso_d  = tx_sr_q[DATA_W-2];
          end
        end
      end
      ST_WAIT_CS: begin
        if (sclk_rise_c && sync_ok_c) begin
          extra_d = 1'b1;
        end
        if (cs_high_c) begin
          frame_err_d = extra_q | (sclk_rise_c & sync_ok_c);
          extra_d     = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_WAIT_CS;
      end
    endcase

    // Holding register: accept if empty or being drained this cycle.
    if (commit_c) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_sr_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_CS;
      sclk_dly_q  <= SPI_SCLK_IDLE;
      cs_dly_q    <= SPI_CS_IDLE;
      flush_cnt_q <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      extra_q     <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
      flush_cnt_q <= flush_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      extra_q     <= extra_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign miso      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table of full frames plus directed
// sequences for short/long frames, overrun, same-cycle drain and mid-frame reset.
module tb_spi_slave_rx;

  logic        clk;
  logic        rst;
  logic        s_clk;
  logic        spi_cs_l;
  logic        mosi;
  logic        miso;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;
  logic        busy;
  logic [4:0]  bit_cnt;

  spi_slave_rx dut (
    .clk(clk), .rst(rst), .s_clk(s_clk), .spi_cs_l(spi_cs_l), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy),
    .bit_cnt(bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Pulse/level counters, only ever incremented here.
  int ferr_cnt;
  int ovr_cnt;
  int val_cnt;
  initial begin
    ferr_cnt = 0;
    ovr_cnt  = 0;
    val_cnt  = 0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun)   ovr_cnt  <= ovr_cnt + 1;
      if (rx_valid)  val_cnt  <= val_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs_l = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    spi_cs_l = 1'b1;
    tick(8);
  endtask

  // n s_clk pulses, half period 4 clk; miso sampled just before each rise.
  task automatic do_bits(input logic [15:0] w, input int n, output logic [15:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'b0;
      tick(4);
      if (i < 16) m[15-i] = miso;
      s_clk = 1'b1;
      tick(4);
      s_clk = 1'b0;
    end
    tick(4);
  endtask

  task automatic frame(input logic [15:0] w, input int n, output logic [15:0] m);
    cs_low();
    do_bits(w, n, m);
    cs_high();
  endtask

  typedef struct {
    logic [15:0] mosi_w;
    logic [15:0] tx_w;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] m;
  int          f0, o0, v0;
  logic        hit;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    s_clk    = 1'b0;
    spi_cs_l = 1'b1;
    mosi     = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b1;

    vecs[0] = '{16'h1231, 16'hA234, 16'h1231, 16'hA234};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'h8001, 16'h5A5A, 16'h8001, 16'h5A5A};

    // Reset state
    tick(3);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    tick(8);

    // Full frames with rx_ready held high
    for (int i = 0; i < 4; i++) begin
      tx_data = vecs[i].tx_w;
      f0 = ferr_cnt;
      v0 = val_cnt;
      frame(vecs[i].mosi_w, 16, m);
      chk($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
      chk($sformatf("vec%0d_miso", i), 32'(m), 32'(vecs[i].exp_miso));
      chk($sformatf("vec%0d_frame_err", i), 32'(ferr_cnt - f0), 32'd0);
      chk($sformatf("vec%0d_valid_cycles", i), 32'(val_cnt - v0), 32'd1);
    end

    // Short frame: 8 bits
    f0 = ferr_cnt;
    v0 = val_cnt;
    frame(16'hC3C3, 8, m);
    chk("short_frame_err", 32'(ferr_cnt - f0), 32'd1);
    chk("short_no_valid", 32'(val_cnt - v0), 32'd0);
    chk("short_bit_cnt", 32'(bit_cnt), 32'd8);
    tick(10);
    chk("short_bit_cnt_hold", 32'(bit_cnt), 32'd8);
    chk("short_rx_data_kept", 32'(rx_data), 32'h8001);

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    frame(16'h2452, 16, m);
    frame(16'h1264, 16, m);
    chk("ovr_rx_data", 32'(rx_data), 32'h2452);
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_valid_held", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    chk("ovr_valid_before_edge", 32'(rx_valid), 32'h1);
    tick(1);
    chk("ovr_valid_drop", 32'(rx_valid), 32'h0);

    // rx_ready raised exactly in the commit cycle of the second word
    rx_ready = 1'b0;
    frame(16'h1231, 16, m);
    chk("drain_first_valid", 32'(rx_valid), 32'h1);
    o0 = ovr_cnt;
    hit = 1'b0;
    cs_low();
    fork
      do_bits(16'hA234, 16, m);
      begin
        for (int k = 0; k < 600; k++) begin
          @(negedge clk);
          if (busy && bit_cnt == 5'd16) begin
            rx_ready = 1'b1;
            @(posedge clk);
            #1;
            rx_ready = 1'b0;
            hit = 1'b1;
            break;
          end
        end
      end
    join
    cs_high();
    chk("drain_commit_seen", 32'(hit), 32'h1);
    chk("drain_rx_data", 32'(rx_data), 32'hA234);
    chk("drain_valid", 32'(rx_valid), 32'h1);
    chk("drain_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    rx_ready = 1'b1;
    tick(2);
    chk("drain_empty", 32'(rx_valid), 32'h0);

    // 17 clocks in one frame
    f0 = ferr_cnt;
    v0 = val_cnt;
    frame(16'h1264, 17, m);
    chk("long_rx_data", 32'(rx_data), 32'h1264);
    chk("long_frame_err", 32'(ferr_cnt - f0), 32'd1);
    chk("long_valid_cycles", 32'(val_cnt - v0), 32'd1);

    // Reset after 5 bits with cs held low
    tx_data = 16'h3C96;
    cs_low();
    do_bits(16'h1231, 5, m);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    f0 = ferr_cnt;
    tick(10);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_bit_cnt", 32'(bit_cnt), 32'h0);
    chk("midrst_valid", 32'(rx_valid), 32'h0);
    chk("midrst_miso", 32'(miso), 32'h0);
    cs_high();
    chk("midrst_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    v0 = val_cnt;
    frame(16'h1231, 16, m);
    chk("midrst_rx_data", 32'(rx_data), 32'h1231);
    chk("midrst_miso_word", 32'(m), 32'h3C96);
    chk("midrst_valid_cycles", 32'(val_cnt - v0), 32'd1);
    chk("midrst_frame_err", 32'(ferr_cnt - f0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
